wb_com_nslave: RTL and testbench
================================

Name: wb_com_nslave

Overview:
Parametrised single-master to N-slave pipelined Wishbone B4 interconnect, successor to the fixed 2x2 crossbar used between the CPU cluster and the memory/peripheral fabric. It decodes each request against per-slave base/mask windows and routes it to the matching slave. It tracks outstanding transactions so responses return in order from the slave that owns them. Unmapped addresses and hung slaves terminate with an error response.

Parameters:
N_SLAVES, 4, number of slave ports (1..16)
AWIDTH, 32, address width
DWIDTH, 32, data width (multiple of 8)
ADDR_BASE, {N_SLAVES*AWIDTH} packed, slave i base at bits [i*AWIDTH +: AWIDTH]
ADDR_MASK, {N_SLAVES*AWIDTH} packed, slave i offset mask; set bits are don't-care in decode
MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests (1..15)
TIMEOUT, 255, idle cycles with outstanding>0 before abort; 0 disables

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
m_wb_adr_i  in  AWIDTH  master address
m_wb_dat_i  in  DWIDTH  master write data
m_wb_sel_i  in  DWIDTH/8  byte selects
m_wb_cyc_i / m_wb_stb_i / m_wb_we_i  in  1 each  master cycle/strobe/write
m_wb_dat_o  out  DWIDTH  read data to master
m_wb_stall_o / m_wb_ack_o / m_wb_err_o  out  1 each  stall/ack/error to master
s_wb_adr_o  out  N_SLAVES*AWIDTH  per-slave address (broadcast copy)
s_wb_dat_o  out  N_SLAVES*DWIDTH  per-slave write data (broadcast)
s_wb_sel_o  out  N_SLAVES*DWIDTH/8  per-slave byte selects
s_wb_we_o  out  N_SLAVES  per-slave write enable
s_wb_cyc_o / s_wb_stb_o  out  N_SLAVES  per-slave cycle/strobe
s_wb_dat_i  in  N_SLAVES*DWIDTH  per-slave read data
s_wb_stall_i / s_wb_ack_i / s_wb_err_i  in  N_SLAVES  per-slave stall/ack/error

Behaviour:
- Decode: hit_i = ((adr & ~MASK_i) == (BASE_i & ~MASK_i)). Lowest-index hit wins. No hit = unmapped.
- State: cur_sel (owner slave index, valid flag), out_cnt (0..MAX_OUTSTANDING), to_cnt (timeout), err_pend.
- Reset: cur_sel invalid, out_cnt=0, to_cnt=0, err_pend=0. All s_wb_cyc_o/s_wb_stb_o=0; m_wb_ack_o=m_wb_err_o=0; m_wb_stall_o=0; m_wb_dat_o=0.
- Accept = m_wb_cyc_i & m_wb_stb_i & ~m_wb_stall_o.
- Stall is asserted when any of these holds:
  - out_cnt==MAX_OUTSTANDING;
  - the decoded target differs from a valid cur_sel and out_cnt!=0;
  - the request is unmapped and out_cnt!=0;
  - err_pend is set;
  - the selected slave's stall_i is set.
- Request path is combinational, 0 added latency. s_wb_stb_o[t]=m_wb_stb_i & ~blocking stall for target t. s_wb_cyc_o[cur_sel]=m_wb_cyc_i while cur_sel valid or target t is being issued. Stall is never gated by its own stb.
- On a mapped accept: cur_sel<=target, out_cnt++.
- Response: m_wb_ack_o=s_wb_ack_i[cur_sel] & m_wb_cyc_i & out_cnt!=0. m_wb_err_o follows the same rule with s_wb_err_i, OR err_pend. m_wb_dat_o=s_wb_dat_i[cur_sel].
  - A response decrements out_cnt. Accept plus response in the same cycle leaves out_cnt unchanged.
  - Acks/errs from non-owner slaves, or with out_cnt==0, are ignored.
- Unmapped accept (only possible with out_cnt==0): no slave strobed; err_pend=1 for exactly one cycle, giving m_wb_err_o one cycle after accept.
- When out_cnt returns to 0, cur_sel stays valid (re-use) until a different target is accepted.
- Master drops m_wb_cyc_i: all s_wb_cyc_o drop the same cycle. Next cycle: out_cnt=0, to_cnt=0, cur_sel invalid, err_pend=0. Late responses are ignored.
- Timeout (TIMEOUT>0): to_cnt increments each cycle out_cnt>0 with no owner response, and clears on any response.
  - When to_cnt==TIMEOUT: m_wb_err_o pulses one cycle and s_wb_cyc_o[cur_sel] is forced 0 for that cycle.
  - Next cycle: out_cnt=0, to_cnt=0, cur_sel invalid.
  - The master sees exactly one error for the whole aborted batch.
- Async rst_i mid-transfer returns all state to reset values immediately; outputs are reset while rst_i is high.

Test Plan:
- N=4; BASE={0x8000_0000,0x0010_0000,0x0000_2000,0x0}; MASK={0xFF,0x000F_FFFF,0x0FFF,0x0FFF}. Read 0x2004 -> only s_wb_stb_o[1] pulses; slave1 acks 0xDEAD_BEEF after 2 cycles -> m_wb_ack_o=1, m_wb_dat_o=0xDEAD_BEEF; out_cnt 1->0.
- Pipelined: 4 back-to-back reads to 0x0010_0000..0x0010_000C, slave never acks until 4th accept -> 5th request stalled (MAX=4); 4 acks return in order, stall releases when out_cnt<4.
- Target switch: read 0x0 (slave0) outstanding, then read 0x2000 -> stalled until slave0 ack; slave1 strobed the cycle after the ack.
- Unmapped: read 0x4000_0000 with out_cnt=0 -> no s_wb_stb_o, m_wb_err_o=1 exactly one cycle after accept; read while out_cnt=1 -> stalled.
- Timeout: TIMEOUT=8, read slave2 (0x0010_0000) with no ack -> m_wb_err_o single pulse 8 cycles after the last activity, s_wb_cyc_o[2]=0 that cycle, late ack ignored.
- Reset/cyc abort: assert rst_i with 2 outstanding -> all outputs 0 same cycle. Separately, drop m_wb_cyc_i with 3 outstanding -> s_wb_cyc_o all 0 immediately; subsequent acks do not reach m_wb_ack_o.

Source files
------------

// File: rtl/wb_com_nslave.sv
// Single-master to N-slave pipelined Wishbone B4 interconnect.
// Requests are routed by base/mask windows; responses return in order from the owning slave.
module wb_com_nslave #(
    parameter int                          N_SLAVES        = 4,
    parameter int                          AWIDTH          = 32,
    parameter int                          DWIDTH          = 32,
    parameter logic [N_SLAVES*AWIDTH-1:0]  ADDR_BASE       = '0,
    parameter logic [N_SLAVES*AWIDTH-1:0]  ADDR_MASK       = '0,
    parameter int                          MAX_OUTSTANDING = 4,
    parameter int                          TIMEOUT         = 255
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [AWIDTH-1:0]              m_wb_adr_i,
    input  logic [DWIDTH-1:0]              m_wb_dat_i,
    input  logic [DWIDTH/8-1:0]            m_wb_sel_i,
    input  logic                           m_wb_cyc_i,
    input  logic                           m_wb_stb_i,
    input  logic                           m_wb_we_i,
    output logic [DWIDTH-1:0]              m_wb_dat_o,
    output logic                           m_wb_stall_o,
    output logic                           m_wb_ack_o,
    output logic                           m_wb_err_o,
    output logic [N_SLAVES*AWIDTH-1:0]     s_wb_adr_o,
    output logic [N_SLAVES*DWIDTH-1:0]     s_wb_dat_o,
    output logic [N_SLAVES*(DWIDTH/8)-1:0] s_wb_sel_o,
    output logic [N_SLAVES-1:0]            s_wb_we_o,
    output logic [N_SLAVES-1:0]            s_wb_cyc_o,
    output logic [N_SLAVES-1:0]            s_wb_stb_o,
    input  logic [N_SLAVES*DWIDTH-1:0]     s_wb_dat_i,
    input  logic [N_SLAVES-1:0]            s_wb_stall_i,
    input  logic [N_SLAVES-1:0]            s_wb_ack_i,
    input  logic [N_SLAVES-1:0]            s_wb_err_i
);

    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TO_LIM  = TW'(TIMEOUT);

    logic [SW-1:0] cur_sel_q, cur_sel_d;
    logic          cur_vld_q, cur_vld_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [TW-1:0] to_cnt_q,  to_cnt_d;
    logic          err_pend_q, err_pend_d;

    logic [SW-1:0] tgt;
    logic          hit_any;
    logic          outstanding;
    logic          timeout_hit;
    logic          block;
    logic          stall;
    logic          issue;
    logic          accept;
    logic          own_ack;
    logic          own_err;
    logic          resp;

    // Lowest index wins: scan downwards so the last assignment is the smallest hit.
    always_comb begin
        hit_any = 1'b0;
        tgt     = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if ((m_wb_adr_i & ~ADDR_MASK[i*AWIDTH +: AWIDTH]) ==
                (ADDR_BASE[i*AWIDTH +: AWIDTH] & ~ADDR_MASK[i*AWIDTH +: AWIDTH])) begin
                hit_any = 1'b1;
                tgt     = SW'(i);
            end
        end
    end

    // The abort cycle also blocks new requests so nothing is issued into a batch being discarded.
    always_comb begin
        outstanding = (out_cnt_q != '0);
        timeout_hit = (TIMEOUT != 0) && m_wb_cyc_i && outstanding && (to_cnt_q == TO_LIM);
        block       = (out_cnt_q == CNT_MAX)
                    | (hit_any & cur_vld_q & (tgt != cur_sel_q) & outstanding)
                    | (~hit_any & outstanding)
                    | err_pend_q
                    | timeout_hit;
        stall       = block | (hit_any & s_wb_stall_i[tgt]);
        issue       = m_wb_cyc_i & m_wb_stb_i & hit_any & ~block & ~rst_i;
        accept      = m_wb_cyc_i & m_wb_stb_i & ~stall & ~rst_i;
        own_ack     = m_wb_cyc_i & cur_vld_q & outstanding & ~timeout_hit & s_wb_ack_i[cur_sel_q];
        own_err     = m_wb_cyc_i & cur_vld_q & outstanding & ~timeout_hit & s_wb_err_i[cur_sel_q];
        resp        = own_ack | own_err;
    end

    always_comb begin
        cur_sel_d  = cur_sel_q;
        cur_vld_d  = cur_vld_q;
        out_cnt_d  = out_cnt_q;
        to_cnt_d   = '0;
        err_pend_d = 1'b0;
        if (!m_wb_cyc_i || timeout_hit) begin
            cur_vld_d = 1'b0;
            out_cnt_d = '0;
        end else begin
            err_pend_d = accept & ~hit_any;
            if (accept && hit_any) begin
                cur_sel_d = tgt;
                cur_vld_d = 1'b1;
            end
            unique case ({accept & hit_any, resp})
                2'b10:   out_cnt_d = out_cnt_q + CW'(1);
                2'b01:   out_cnt_d = out_cnt_q - CW'(1);
                default: out_cnt_d = out_cnt_q;
            endcase
            if (!resp && outstanding && (TIMEOUT != 0))
                to_cnt_d = to_cnt_q + TW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cur_sel_q  <= '0;
            cur_vld_q  <= 1'b0;
            out_cnt_q  <= '0;
            to_cnt_q   <= '0;
            err_pend_q <= 1'b0;
        end else begin
            cur_sel_q  <= cur_sel_d;
            cur_vld_q  <= cur_vld_d;
            out_cnt_q  <= out_cnt_d;
            to_cnt_q   <= to_cnt_d;
            err_pend_q <= err_pend_d;
        end
    end

    assign s_wb_adr_o = {N_SLAVES{m_wb_adr_i}};
    assign s_wb_dat_o = {N_SLAVES{m_wb_dat_i}};
    assign s_wb_sel_o = {N_SLAVES{m_wb_sel_i}};
    assign s_wb_we_o  = {N_SLAVES{m_wb_we_i}};

    always_comb begin
        s_wb_cyc_o   = '0;
        s_wb_stb_o   = '0;
        m_wb_dat_o   = '0;
        m_wb_stall_o = ~rst_i & stall;
        m_wb_ack_o   = ~rst_i & own_ack;
        m_wb_err_o   = ~rst_i & (own_err | err_pend_q | timeout_hit);
        for (int t = 0; t < N_SLAVES; t++) begin
            s_wb_stb_o[t] = issue & (tgt == SW'(t));
            s_wb_cyc_o[t] = ~rst_i & m_wb_cyc_i &
                            ((cur_vld_q & (cur_sel_q == SW'(t)) & ~timeout_hit) |
                             (issue & (tgt == SW'(t))));
        end
        if (!rst_i && cur_vld_q)
            m_wb_dat_o = s_wb_dat_i[int'(cur_sel_q)*DWIDTH +: DWIDTH];
    end

endmodule

// File: tb/tb_wb_com_nslave.sv
// Bench for wb_com_nslave: directed scenarios plus randomized traffic against a
// queue-based model of outstanding requests.
module tb_wb_com_nslave;

    localparam int NS   = 4;
    localparam int MAXO = 4;
    localparam int TO   = 8;
    localparam logic [NS*32-1:0] BASE = {32'h8000_0000, 32'h0010_0000, 32'h0000_2000, 32'h0000_0000};
    localparam logic [NS*32-1:0] MASK = {32'h0000_00FF, 32'h000F_FFFF, 32'h0000_0FFF, 32'h0000_0FFF};

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     m_adr;
    logic [31:0]     m_dat;
    logic [3:0]      m_sel;
    logic            m_cyc, m_stb, m_we;
    logic [31:0]     m_dat_o;
    logic            m_stall_o, m_ack_o, m_err_o;
    logic [NS*32-1:0] s_adr_o, s_dat_o;
    logic [NS*4-1:0] s_sel_o;
    logic [NS-1:0]   s_we_o, s_cyc_o, s_stb_o;
    logic [NS*32-1:0] s_dat;
    logic [NS-1:0]   s_stall, s_ack, s_err;

    always #5 clk = ~clk;

    wb_com_nslave #(
        .N_SLAVES(NS), .AWIDTH(32), .DWIDTH(32),
        .ADDR_BASE(BASE), .ADDR_MASK(MASK),
        .MAX_OUTSTANDING(MAXO), .TIMEOUT(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_wb_adr_i(m_adr), .m_wb_dat_i(m_dat), .m_wb_sel_i(m_sel),
        .m_wb_cyc_i(m_cyc), .m_wb_stb_i(m_stb), .m_wb_we_i(m_we),
        .m_wb_dat_o(m_dat_o), .m_wb_stall_o(m_stall_o),
        .m_wb_ack_o(m_ack_o), .m_wb_err_o(m_err_o),
        .s_wb_adr_o(s_adr_o), .s_wb_dat_o(s_dat_o), .s_wb_sel_o(s_sel_o),
        .s_wb_we_o(s_we_o), .s_wb_cyc_o(s_cyc_o), .s_wb_stb_o(s_stb_o),
        .s_wb_dat_i(s_dat), .s_wb_stall_i(s_stall),
        .s_wb_ack_i(s_ack), .s_wb_err_i(s_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: queue of owner indices for accepted-but-unanswered requests.
    int mq[$];
    int own;
    bit ownv;
    int idle;
    bit errp;

    logic          obs_stall, obs_ack, obs_err;
    logic [31:0]   obs_dat;
    logic [NS-1:0] obs_stb, obs_cyc;

    function automatic void model_reset();
        mq.delete();
        own  = 0;
        ownv = 1'b0;
        idle = 0;
        errp = 1'b0;
    endfunction

    function automatic int decode(input logic [31:0] a);
        logic [31:0] b, m;
        for (int i = 0; i < NS; i++) begin
            b = BASE[i*32 +: 32];
            m = MASK[i*32 +: 32];
            if ((a & ~m) == (b & ~m)) return i;
        end
        return -1;
    endfunction

    // Evaluate one cycle: inputs are already driven; check outputs, advance the model, move to next negedge.
    task automatic step();
        int n, tgt;
        bit mapped, tohit, blk, stl, acc, ack, serr, err;
        logic [NS-1:0] stbv, cycv;
        #1;
        n      = mq.size();
        tgt    = decode(m_adr);
        mapped = (tgt >= 0);
        tohit  = m_cyc && n > 0 && idle == TO;
        blk    = (n == MAXO) || (mapped && ownv && tgt != own && n > 0) ||
                 (!mapped && n > 0) || errp || tohit;
        stl    = blk || (mapped && s_stall[tgt]);
        stbv   = (m_cyc && m_stb && mapped && !blk) ? NS'(1 << tgt) : '0;
        cycv   = m_cyc ? (stbv | ((ownv && !tohit) ? NS'(1 << own) : '0)) : '0;
        ack    = m_cyc && n > 0 && ownv && !tohit && s_ack[own];
        serr   = m_cyc && n > 0 && ownv && !tohit && s_err[own];
        err    = serr || errp || tohit;

        obs_stall = m_stall_o; obs_ack = m_ack_o; obs_err = m_err_o;
        obs_dat = m_dat_o; obs_stb = s_stb_o; obs_cyc = s_cyc_o;

        check_eq("stall", m_stall_o, stl);
        check_eq("s_stb", s_stb_o, stbv);
        check_eq("s_cyc", s_cyc_o, cycv);
        check_eq("ack", m_ack_o, ack);
        check_eq("err", m_err_o, err);
        if (ack) check_eq("rdata", m_dat_o, s_dat[own*32 +: 32]);
        if (stbv != '0) check_eq("s_adr", s_adr_o[tgt*32 +: 32], m_adr);

        acc = m_cyc && m_stb && !stl;
        if (!m_cyc || tohit) begin
            model_reset();
        end else begin
            if (ack || serr) void'(mq.pop_front());
            if (acc && mapped) begin
                mq.push_back(tgt);
                own  = tgt;
                ownv = 1'b1;
            end
            errp = acc && !mapped;
            if (ack || serr) idle = 0;
            else if (n > 0)  idle = idle + 1;
            else             idle = 0;
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 8))
            0, 1:    return 32'h0000_0000 | ($urandom & 32'h0000_0FFF);
            2, 3:    return 32'h0000_2000 | ($urandom & 32'h0000_0FFF);
            4, 5:    return 32'h0010_0000 | ($urandom & 32'h000F_FFFF);
            6:       return 32'h8000_0000 | ($urandom & 32'h0000_00FF);
            7:       return ($urandom_range(0, 1) == 0) ? 32'h4000_0000 : 32'h0000_1000;
            default: return $urandom;
        endcase
    endfunction

    int err_cnt, err_at;
    logic cyc2_at_err;
    int ackp;

    initial begin
        rst = 1'b1;
        m_adr = '0; m_dat = '0; m_sel = '0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        s_dat = '0; s_stall = '1; s_ack = '1; s_err = '0;
        model_reset();

        repeat (2) @(negedge clk);
        m_cyc = 1'b1; m_stb = 1'b1;
        #1;
        check_eq("rst_stall", m_stall_o, 1'b0);
        check_eq("rst_ack", m_ack_o, 1'b0);
        check_eq("rst_err", m_err_o, 1'b0);
        check_eq("rst_s_cyc", s_cyc_o, '0);
        check_eq("rst_s_stb", s_stb_o, '0);
        check_eq("rst_dat", m_dat_o, '0);

        @(negedge clk);
        rst = 1'b0; s_stall = '0; s_ack = '0;
        m_cyc = 1'b0; m_stb = 1'b0;
        step();

        // Single read to slave 1 with a two-cycle ack delay.
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_2004;
        step();
        check_eq("rd_stb_s1", obs_stb, 4'b0010);
        m_stb = 1'b0;
        step();
        step();
        s_ack = 4'b0010; s_dat[32 +: 32] = 32'hDEAD_BEEF;
        step();
        check_eq("rd_ack", obs_ack, 1'b1);
        check_eq("rd_data", obs_dat, 32'hDEAD_BEEF);
        s_ack = '0;
        step();

        // Pipelined reads fill the window; the fifth is stalled.
        m_cyc = 1'b0; step(); m_cyc = 1'b1; m_stb = 1'b1;
        for (int k = 0; k < 5; k++) begin
            m_adr = 32'h0010_0000 + 32'(4 * (k % 4));
            step();
            check_eq($sformatf("pipe_stall%0d", k), obs_stall, (k == 4));
        end
        s_ack = 4'b0100;
        for (int k = 0; k < 6; k++) step();
        s_ack = '0; m_stb = 1'b0;
        step();

        // Target switch: slave0 read outstanding blocks a slave1 read until the ack.
        m_cyc = 1'b0; step(); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0;
        step();
        m_adr = 32'h2000;
        step();
        check_eq("sw_stall", obs_stall, 1'b1);
        s_ack = 4'b0001;
        step();
        s_ack = '0;
        step();
        check_eq("sw_stb_s1", obs_stb, 4'b0010);
        m_stb = 1'b0;
        step(); step();

        // Unmapped read gets an error one cycle after accept; unmapped while busy is stalled.
        m_cyc = 1'b0; step(); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h4000_0000;
        step();
        check_eq("um_stb", obs_stb, '0);
        m_stb = 1'b0;
        step();
        check_eq("um_err", obs_err, 1'b1);
        m_stb = 1'b1; m_adr = 32'h0; step();
        m_adr = 32'h4000_0000; step();
        check_eq("um_busy_stall", obs_stall, 1'b1);
        m_stb = 1'b0;

        // Timeout on slave 2, then a late ack.
        m_cyc = 1'b0; step(); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0010_0000;
        step();
        m_stb = 1'b0;
        err_cnt = 0; err_at = -1; cyc2_at_err = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            s_ack = (k == 10) ? 4'b0100 : 4'b0000;
            step();
            if (obs_err) begin
                err_cnt++;
                err_at = k;
                cyc2_at_err = obs_cyc[2];
            end
        end
        s_ack = '0;
        check_eq("to_err_count", err_cnt, 1);
        check_eq("to_err_cycle", err_at, TO + 1);
        check_eq("to_cyc2", cyc2_at_err, 1'b0);

        // Dropping cyc with three outstanding discards them.
        m_cyc = 1'b0; step(); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0000_2010;
        repeat (3) step();
        m_stb = 1'b0; m_cyc = 1'b0; s_ack = 4'b0010;
        step();
        check_eq("drop_s_cyc", obs_cyc, '0);
        m_cyc = 1'b1;
        step();
        check_eq("drop_late_ack", obs_ack, 1'b0);
        s_ack = '0;

        // Randomized traffic with slave responsiveness varying by phase.
        ackp = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 40 == 0) begin
                case ($urandom_range(0, 3))
                    0: ackp = 0;
                    1: ackp = 20;
                    2: ackp = 50;
                    default: ackp = 90;
                endcase
            end
            m_cyc = ($urandom_range(0, 99) < 97);
            m_stb = $urandom_range(0, 1);
            m_adr = pick_addr();
            m_dat = $urandom;
            m_sel = 4'($urandom);
            m_we  = $urandom_range(0, 1);
            for (int i = 0; i < NS; i++) begin
                s_dat[i*32 +: 32] = $urandom;
                s_ack[i]   = ($urandom_range(0, 99) < ackp);
                s_err[i]   = ($urandom_range(0, 99) < 3);
                s_stall[i] = ($urandom_range(0, 99) < 10);
            end
            step();
        end

        // Asynchronous reset with two outstanding requests.
        s_ack = '0; s_err = '0; s_stall = '0;
        m_cyc = 1'b0; step(); m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0010_0040;
        step(); step();
        s_ack = 4'b0100;
        rst = 1'b1;
        #1;
        check_eq("arst_ack", m_ack_o, 1'b0);
        check_eq("arst_err", m_err_o, 1'b0);
        check_eq("arst_stall", m_stall_o, 1'b0);
        check_eq("arst_s_cyc", s_cyc_o, '0);
        check_eq("arst_s_stb", s_stb_o, '0);
        check_eq("arst_dat", m_dat_o, '0);
        model_reset();
        @(negedge clk);
        rst = 1'b0; s_ack = '0;
        step();
        check_eq("post_rst_stb", obs_stb, 4'b0100);
        m_stb = 1'b0;
        repeat (3) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
